// File: rtl/updown_mod_counter.sv
// Parametrised up/down modulo counter with runtime modulus, periodic or one-shot
// mode, a registered one-cycle terminal-count pulse for cascading, and a DONE flag.
module updown_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             count_en,
    input  logic             up_dn,
    input  logic             one_shot,
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld,
    input  logic [WIDTH-1:0] modulus,
    output logic [WIDTH-1:0] count,
    output logic             cout,
    output logic             done
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_e;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [WIDTH-1:0] count_q;
    logic             cout_q;
    logic             done_q;

    logic             step;
    logic             terminal;
    logic [WIDTH-1:0] count_d;

    // A step is only possible in RUN; DONE swallows enables until a load or reset.
    assign step     = (state_q == S_RUN) && clk_en && count_en;
    assign terminal = up_dn ? (count_q == modulus) : (count_q == '0);

    // Value taken on a non-terminal step or a periodic terminal wrap.
    always_comb begin
        count_d = count_q;
        if (terminal) begin
            count_d = up_dn ? '0 : modulus;
        end else begin
            count_d = up_dn ? count_q + ONE : count_q - ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_RUN;
            count_q <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (ld_en) begin
            state_q <= S_RUN;
            count_q <= ld;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            cout_q <= 1'b0;
            if (step) begin
                if (terminal) begin
                    cout_q <= 1'b1;
                    if (one_shot) begin
                        // One-shot expiry freezes the count at its terminal value.
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        count_q <= count_d;
                    end
                end else begin
                    count_q <= count_d;
                end
            end
        end
    end

    assign count = count_q;
    assign cout  = cout_q;
    assign done  = done_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: directed test-plan sequences followed by
// random stimulus, checked against an arithmetic reference model.
module tb_updown_mod_counter;

    localparam int W    = 4;
    localparam int SPAN = 1 << W;

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_en;
    logic         count_en;
    logic         up_dn;
    logic         one_shot;
    logic         ld_en;
    logic [W-1:0] ld;
    logic [W-1:0] modulus;
    logic [W-1:0] count;
    logic         cout;
    logic         done;

    updown_mod_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_en   (clk_en),
        .count_en (count_en),
        .up_dn    (up_dn),
        .one_shot (one_shot),
        .ld_en    (ld_en),
        .ld       (ld),
        .modulus  (modulus),
        .count    (count),
        .cout     (cout),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    cnt;
        bit    co;
        bit    dn;
        string name;
    } exp_t;

    exp_t exp_q[$];

    int n_vec  = 0;
    int n_miss = 0;
    bit stim_done = 1'b0;

    // Reference model state: plain integers following the behavioural rules.
    int m_cnt  = 0;
    bit m_done = 1'b0;
    bit m_cout = 1'b0;

    task automatic apply(input bit r, input bit ce, input bit en, input bit ud,
                         input bit os, input bit le, input int lv, input int mv,
                         input string name);
        exp_t e;
        bit   term;
        @(negedge clk);
        rst      = r;
        clk_en   = ce;
        count_en = en;
        up_dn    = ud;
        one_shot = os;
        ld_en    = le;
        ld       = W'(lv);
        modulus  = W'(mv);

        m_cout = 1'b0;
        if (!r) begin
            m_cnt  = 0;
            m_done = 1'b0;
        end else if (le) begin
            m_cnt  = lv % SPAN;
            m_done = 1'b0;
        end else if (!m_done && ce && en) begin
            term = ud ? (m_cnt == mv) : (m_cnt == 0);
            if (term) begin
                m_cout = 1'b1;
                if (os) m_done = 1'b1;
                else    m_cnt  = ud ? 0 : mv;
            end else begin
                m_cnt = (m_cnt + (ud ? 1 : SPAN - 1)) % SPAN;
            end
        end
        e.cnt  = m_cnt;
        e.co   = m_cout;
        e.dn   = m_done;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Convenience: a plain enabled step.
    task automatic stepn(input int n, input bit ud, input bit os, input int mv,
                         input string name);
        for (int i = 0; i < n; i++) apply(1, 1, 1, ud, os, 0, 0, mv, name);
    endtask

    // Monitor: one comparison per clock once expectations are queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (count !== W'(e.cnt) || cout !== e.co || done !== e.dn) begin
                    n_miss++;
                    $display("FAIL %s: got count=%0d cout=%b done=%b, expected count=%0d cout=%b done=%b",
                             e.name, count, cout, done, e.cnt, e.co, e.dn);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "timeout");
    end

    initial begin
        apply(0, 0, 0, 1, 0, 0, 0, 5, "reset");

        // Periodic up, M=5: 0..5 wrap with cout after 5->0.
        stepn(14, 1, 0, 5, "periodic_up");

        // Periodic down, M=9 from 3, then clk_en gap.
        apply(1, 1, 1, 0, 0, 1, 3, 9, "load3");
        stepn(6, 0, 0, 9, "periodic_down");
        for (int i = 0; i < 3; i++) apply(1, 0, 1, 0, 0, 0, 0, 9, "clk_en_gap");
        stepn(2, 0, 0, 9, "periodic_down_resume");

        // One-shot down from 2, expiry, then reload 4.
        apply(1, 0, 0, 0, 1, 1, 2, 9, "load2");
        stepn(5, 0, 1, 9, "one_shot_down");
        apply(1, 1, 1, 0, 0, 0, 0, 9, "done_mode_switch");
        apply(1, 1, 1, 0, 0, 0, 0, 9, "done_mode_switch");
        apply(1, 0, 0, 0, 1, 1, 4, 9, "reload4");
        stepn(2, 0, 1, 9, "resume_after_reload");

        // Load wins over a simultaneous terminal step.
        apply(1, 1, 1, 1, 0, 1, 5, 5, "load5");
        apply(1, 1, 1, 1, 0, 1, 1, 5, "load_over_terminal");
        // Reset wins over load.
        apply(0, 1, 1, 1, 0, 1, 9, 5, "reset_over_load");
        // Reset out of DONE.
        apply(1, 1, 1, 1, 1, 1, 5, 5, "load5_os");
        stepn(2, 1, 1, 5, "expire_up");
        apply(0, 1, 1, 1, 1, 0, 0, 5, "reset_in_done");
        stepn(2, 1, 0, 5, "after_reset_in_done");

        // Out-of-range up: 14,15,0 without cout, then normal wrap at 5.
        apply(1, 1, 1, 1, 0, 1, 14, 5, "load14");
        stepn(9, 1, 0, 5, "out_of_range_up");
        // Out-of-range down decrements normally.
        apply(1, 1, 1, 0, 0, 1, 12, 5, "load12");
        stepn(4, 0, 0, 5, "out_of_range_down");

        // Modulus 0: every step terminal.
        apply(1, 0, 0, 1, 0, 1, 0, 0, "load0");
        stepn(3, 1, 0, 0, "mod0_periodic");
        stepn(2, 0, 0, 0, "mod0_periodic_down");
        stepn(2, 1, 1, 0, "mod0_one_shot");

        // Direction flip at 3 with M=7.
        apply(1, 1, 1, 1, 0, 1, 3, 7, "load3_m7");
        stepn(1, 0, 0, 7, "dir_flip");
        stepn(2, 1, 0, 7, "dir_flip_back");

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            int mv;
            mv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, SPAN - 1));
            apply($urandom_range(0, 99) >= 2,
                  $urandom_range(0, 99) < 75,
                  $urandom_range(0, 99) < 85,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 8,
                  int'($urandom_range(0, SPAN - 1)),
                  mv,
                  "random");
        end

        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
